// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared fetch definitions: FSM encodings, instruction size, fifo_data layout
package inst_fetch_unit_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PUSH = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int INST_BYTES = 4;

  // fifo_data layout is {pc, inst}; decode uses the same offsets
  localparam int FD_INST_LSB = 0;

  function automatic int fd_pc_lsb(input int inst_width);
    return inst_width;
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch FSM feeding the instruction FIFO
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH-1:0]            redirect_pc,
  output logic                             imem_req,
  output logic [ADDR_WIDTH-1:0]            imem_addr,
  input  logic                             imem_gnt,
  input  logic                             imem_rvalid,
  input  logic [INST_WIDTH-1:0]            imem_rdata,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_data
);

  logic [1:0]                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]              pc_q, pc_d;
  logic [ADDR_WIDTH+INST_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]              redirect_target;

  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(INST_BYTES - 1);

  assign imem_req   = (state_q == S_REQ) && !redirect_valid;
  assign imem_addr  = pc_q;
  assign fifo_write = (state_q == S_PUSH) && !fifo_full && !redirect_valid;
  assign fifo_data  = data_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    // A redirect always wins; only the state transition depends on what is in flight
    if (redirect_valid) begin
      pc_d = redirect_target;
    end
    case (state_q)
      S_REQ: begin
        if (!redirect_valid && imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          data_d  = {pc_q, imem_rdata};
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (!fifo_full) begin
          pc_d    = pc_q + ADDR_WIDTH'(INST_BYTES);
          state_d = S_REQ;
        end
      end
      default: begin
        // S_DROP: the squashed response still has to drain before a new request
        if (imem_rvalid) state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - cycle-table and free-running checks for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fifo_full;
  logic        fifo_write;
  logic [63:0] fifo_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data(fifo_data)
  );

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        full;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [63:0] data;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] ins(input int n);
    return 32'h1111_0000 + 32'(n);
  endfunction

  function automatic vec_t v(input logic r, input logic rdv, input logic [31:0] rpc,
                             input logic gnt, input logic rv, input logic [31:0] rd,
                             input logic full, input logic req, input logic [31:0] addr,
                             input logic wr, input logic [63:0] data);
    vec_t t;
    t.rst = r; t.rdv = rdv; t.rpc = rpc; t.gnt = gnt; t.rv = rv; t.rd = rd;
    t.full = full; t.req = req; t.addr = addr; t.wr = wr; t.data = data;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; redirect_valid = t.rdv; redirect_pc = t.rpc;
    imem_gnt = t.gnt; imem_rvalid = t.rv; imem_rdata = t.rd; fifo_full = t.full;
  endtask

  initial begin
    logic [63:0] d0, d1, d2, d3, d4, d6, d7;
    d0 = {32'h100, ins(0)}; d1 = {32'h104, ins(1)}; d2 = {32'h108, ins(2)};
    d3 = {32'h10c, ins(3)}; d4 = {32'h2000, ins(4)}; d6 = {32'h5000, ins(6)};
    d7 = {32'hFFFF_FFFC, ins(7)};

    //               rst rdv rpc            gnt rv rd            full req addr          wr data
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   1, 32'h100,      0, 64'h0)); // r0 reset state
    vq[0].gnt = 1'b1;
    vq.push_back(v(0, 0, 0,             0, 1, ins(0),        0,   0, 32'h100,      0, 64'h0));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h100,      1, d0));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h104,      0, d0));
    vq.push_back(v(0, 0, 0,             0, 1, ins(1),        0,   0, 32'h104,      0, d0));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h104,      1, d1));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h108,      0, d1));
    vq.push_back(v(0, 0, 0,             0, 1, ins(2),        0,   0, 32'h108,      0, d1));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h108,      1, d2));
    // grant withheld, slow response, then fifo_full for 5 cycles
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   1, 32'h10c,      0, d2));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h10c,      0, d2));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h10c,      0, d2));
    vq.push_back(v(0, 0, 0,             0, 1, ins(3),        0,   0, 32'h10c,      0, d2));
    for (int i = 0; i < 5; i++)
      vq.push_back(v(0, 0, 0,           0, 0, 0,             1,   0, 32'h10c,      0, d3));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h10c,      1, d3));
    // redirect in S_WAIT, squashed response 4 cycles later
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h110,      0, d3));
    vq.push_back(v(0, 1, 32'h2003,      0, 0, 0,             0,   0, 32'h110,      0, d3));
    for (int i = 0; i < 3; i++)
      vq.push_back(v(0, 0, 0,           0, 0, 0,             0,   0, 32'h2000,     0, d3));
    vq.push_back(v(0, 0, 0,             0, 1, 32'hDEAD_0000, 0,   0, 32'h2000,     0, d3));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h2000,     0, d3));
    vq.push_back(v(0, 0, 0,             0, 1, ins(4),        0,   0, 32'h2000,     0, d3));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h2000,     1, d4));
    // redirect together with rvalid, then redirect in S_REQ with a grant
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h2004,     0, d4));
    vq.push_back(v(0, 1, 32'h3000,      0, 1, 32'hBAD0_0001, 0,   0, 32'h2004,     0, d4));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   1, 32'h3000,     0, d4));
    vq.push_back(v(0, 1, 32'h4000,      1, 0, 0,             0,   0, 32'h3000,     0, d4));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h4000,     0, d4));
    // redirect in S_PUSH: held instruction dropped
    vq.push_back(v(0, 0, 0,             0, 1, ins(5),        0,   0, 32'h4000,     0, d4));
    vq.push_back(v(0, 1, 32'h5000,      0, 0, 0,             0,   0, 32'h4000,     0, {32'h4000, ins(5)}));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h5000,     0, {32'h4000, ins(5)}));
    vq.push_back(v(0, 0, 0,             0, 1, ins(6),        0,   0, 32'h5000,     0, {32'h4000, ins(5)}));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'h5000,     1, d6));
    // pc wrap from 0xFFFFFFFC to 0
    vq.push_back(v(0, 1, 32'hFFFF_FFFF, 0, 0, 0,             0,   0, 32'h5004,     0, d6));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'hFFFF_FFFC, 0, d6));
    vq.push_back(v(0, 0, 0,             0, 1, ins(7),        0,   0, 32'hFFFF_FFFC, 0, d6));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   0, 32'hFFFF_FFFC, 1, d7));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, 32'h0,        0, d7));
    // rst while in S_WAIT
    vq.push_back(v(1, 0, 0,             0, 0, 0,             0,   0, 32'h0,        0, d7));
    vq.push_back(v(0, 0, 0,             0, 0, 0,             0,   1, RPC,          0, 64'h0));
    vq.push_back(v(0, 0, 0,             1, 0, 0,             0,   1, RPC,          0, 64'h0));

    drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      #1 drive(vq[i]);
      @(negedge clk);
      check($sformatf("row%0d imem_req", i),   64'(imem_req),   64'(vq[i].req));
      check($sformatf("row%0d imem_addr", i),  64'(imem_addr),  64'(vq[i].addr));
      check($sformatf("row%0d fifo_write", i), 64'(fifo_write), 64'(vq[i].wr));
      check($sformatf("row%0d fifo_data", i),  fifo_data,       vq[i].data);
      @(posedge clk);
    end

    // Free-running 1-cycle memory: pushes every 3 cycles, pc stepping by 4
    begin
      logic        rv_next;
      logic [31:0] last_rd;
      logic [31:0] exp_pc;
      int          pushes;
      int          last_cyc;
      rv_next = 1'b1;  // request at RPC was granted in the final table row
      last_rd = '0;
      exp_pc  = RPC;
      pushes  = 0;
      last_cyc = -1;
      for (int c = 0; c < 40 && pushes < 4; c++) begin
        #1;
        rst = 0; redirect_valid = 0; redirect_pc = 0; fifo_full = 0; imem_gnt = 1'b1;
        imem_rvalid = rv_next;
        imem_rdata  = 32'hC0DE_0000 + 32'(c);
        if (rv_next) last_rd = imem_rdata;
        @(negedge clk);
        rv_next = imem_req && imem_gnt;
        if (fifo_write) begin
          check($sformatf("free push%0d data", pushes), fifo_data, {exp_pc, last_rd});
          if (last_cyc >= 0)
            check($sformatf("free push%0d spacing", pushes), 64'(c - last_cyc), 64'd3);
          last_cyc = c;
          exp_pc  += 32'd4;
          pushes++;
        end
        @(posedge clk);
      end
      check("free push count", 64'(pushes), 64'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
